// File: rtl/if_fetch_pkg.sv
// Purpose: shared constants and the state encoding for the instruction-fetch stage.
// Ports: none (package).
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic RST_ENABLE        = 1'b1;
  localparam logic STOP              = 1'b1;
  localparam logic NO_STOP           = 1'b0;
  localparam logic IBUS_REQ_ENABLE   = 1'b1;
  localparam logic IBUS_REQ_DISABLE  = 1'b0;

  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10
  } if_state_t;

endpackage

// File: rtl/if_fetch_pc_next.sv
// Purpose: next-PC selection, sequential pc+4 or word-aligned branch target.
// Ports:
//   pc            - current PC
//   branch_flag   - taken branch/jump from ID
//   branch_target - redirect address, low two bits discarded
//   pc_next       - PC to load on an advance edge
module if_fetch_pc_next
  import if_fetch_pkg::*;
(
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  output logic [INST_ADDR_W-1:0] pc_next
);

  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];

  // Modulo-2^32 increment: 32'hFFFFFFFC wraps to zero.
  assign pc_next = branch_flag ? {branch_target[INST_ADDR_W-1:2], 2'b00}
                               : pc + 32'd4;

endmodule

// File: rtl/if_fetch.sv
// Purpose: instruction-fetch stage feeding IF/ID. Owns the PC, drives a
// req/ack instruction bus with arbitrary wait states, and stalls the
// pipeline while a fetch is outstanding.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   stall            - pipeline stall vector, bit 0 freezes PC/IF
//   branch_flag_i    - taken redirect resolved in ID
//   branch_target_i  - redirect address
//   ibus_ack_i       - read data valid this cycle
//   ibus_rdata_i     - read data
//   ibus_req_o       - read request, held until acked
//   ibus_addr_o      - read address
//   if_pc, if_inst   - PC/instruction presented to IF/ID (zero = NOP)
//   stallreq_o       - fetch outstanding
//
// state  | meaning
// S_IDLE | first cycle after reset, no request, NOP to IF/ID
// S_REQ  | request on the bus, waiting for / receiving ack
// S_HOLD | pipeline stalled after ack, buffered instruction presented
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  input  logic                   ibus_ack_i,
  input  logic [INST_W-1:0]      ibus_rdata_i,
  output logic                   ibus_req_o,
  output logic [INST_ADDR_W-1:0] ibus_addr_o,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   stallreq_o
);

  if_state_t             state, state_nxt;
  logic [INST_ADDR_W-1:0] pc, pc_next;
  logic [INST_W-1:0]      inst_buf;
  logic                   advance;
  logic                   capture;

  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  if_fetch_pc_next u_pc_next (
    .pc            (pc),
    .branch_flag   (branch_flag_i),
    .branch_target (branch_target_i),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      inst_buf <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      if (advance) pc <= pc_next;
      if (capture) inst_buf <= ibus_rdata_i;
    end
  end

  // stallreq_o is a function of state and ack only, never of stall.
  always_comb begin
    state_nxt   = state;
    advance     = 1'b0;
    capture     = 1'b0;
    ibus_req_o  = IBUS_REQ_DISABLE;
    ibus_addr_o = pc;
    if_pc       = ZERO_WORD;
    if_inst     = ZERO_WORD;
    stallreq_o  = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        ibus_req_o = IBUS_REQ_ENABLE;
        if (ibus_ack_i) begin
          if_pc   = pc;
          if_inst = ibus_rdata_i;
          if (stall[0] == NO_STOP) begin
            advance = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end
        end else begin
          stallreq_o = 1'b1;
        end
      end
      S_HOLD: begin
        if_pc   = pc;
        if_inst = inst_buf;
        if (stall[0] == NO_STOP) begin
          advance   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
